// File: rtl/id_fwd_stage.sv
// RV32I decode stage: slot register, NUM_FWD-source operand forwarding with load-use stall, ID/EX register
// under valid/ready (1-cycle accept-to-issue; stalls hold the slot, EX backpressure holds the bundle). RV32M_EN adds M-ext decode.
`ifndef ID_FWD_STAGE_TYPES
`define ID_FWD_STAGE_TYPES
`define InstTypeBus    [5:0]
`define NOPInstType    6'd0
`define LUIInstType    6'd1
`define AUIPCInstType  6'd2
`define JALInstType    6'd3
`define JALRInstType   6'd4
`define BEQInstType    6'd5
`define BNEInstType    6'd6
`define BLTInstType    6'd7
`define BGEInstType    6'd8
`define BLTUInstType   6'd9
`define BGEUInstType   6'd10
`define LBInstType     6'd11
`define LHInstType     6'd12
`define LWInstType     6'd13
`define LBUInstType    6'd14
`define LHUInstType    6'd15
`define SBInstType     6'd16
`define SHInstType     6'd17
`define SWInstType     6'd18
`define ADDIInstType   6'd19
`define SLTIInstType   6'd20
`define SLTIUInstType  6'd21
`define XORIInstType   6'd22
`define ORIInstType    6'd23
`define ANDIInstType   6'd24
`define SLLIInstType   6'd25
`define SRLIInstType   6'd26
`define SRAIInstType   6'd27
`define ADDInstType    6'd28
`define SUBInstType    6'd29
`define SLLInstType    6'd30
`define SLTInstType    6'd31
`define SLTUInstType   6'd32
`define XORInstType    6'd33
`define SRLInstType    6'd34
`define SRAInstType    6'd35
`define ORInstType     6'd36
`define ANDInstType    6'd37
`define MULInstType    6'd38
`define MULHInstType   6'd39
`define MULHSUInstType 6'd40
`define MULHUInstType  6'd41
`define DIVInstType    6'd42
`define DIVUInstType   6'd43
`define REMInstType    6'd44
`define REMUInstType   6'd45
`endif

module id_fwd_stage #(
  parameter int NUM_FWD = 2,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    flush_in,
  input  logic                    if_valid_in,
  input  logic [31:0]             if_inst_in,
  input  logic [31:0]             if_pc_in,
  input  logic                    if_pre_to_take_in,
  output logic                    id_ready_out,
  output logic                    rs1_read_out,
  output logic                    rs2_read_out,
  output logic [4:0]              rs1_addr_out,
  output logic [4:0]              rs2_addr_out,
  input  logic [XLEN-1:0]         rs1_data_in,
  input  logic [XLEN-1:0]         rs2_data_in,
  input  logic [NUM_FWD-1:0]      fwd_wreg_in,
  input  logic [NUM_FWD-1:0]      fwd_loading_in,
  input  logic [NUM_FWD*5-1:0]    fwd_waddr_in,
  input  logic [NUM_FWD*XLEN-1:0] fwd_wdata_in,
  input  logic                    ex_ready_in,
  output logic                    ex_valid_out,
  output logic `InstTypeBus       ex_inst_type_out,
  output logic [XLEN-1:0]         ex_rs1_val_out,
  output logic [XLEN-1:0]         ex_rs2_val_out,
  output logic [XLEN-1:0]         ex_imm_out,
  output logic                    ex_rd_out,
  output logic [4:0]              ex_rd_addr_out,
  output logic [31:0]             ex_pc_out,
  output logic                    ex_pre_to_take_out,
  output logic                    ex_illegal_out,
  output logic [CNT_W-1:0]        stall_cnt_out
);

  typedef struct packed {
    logic [5:0]      inst_type;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic            rd;
    logic [4:0]      rd_addr;
    logic [31:0]     pc;
    logic            pre;
    logic            illegal;
  } ex_bundle_t;

  logic             slot_valid_q, slot_valid_d;
  logic [31:0]      slot_inst_q, slot_inst_d;
  logic [31:0]      slot_pc_q, slot_pc_d;
  logic             slot_pre_q, slot_pre_d;
  logic             ex_valid_q, ex_valid_d;
  ex_bundle_t       ex_q, ex_d, issue;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, dec_imm;
  logic `InstTypeBus dec_type;
  logic        dec_rs1, dec_rs2, dec_rd, dec_illegal;

  assign opc    = slot_inst_q[6:0];
  assign f3     = slot_inst_q[14:12];
  assign f7     = slot_inst_q[31:25];
  assign imm_i  = {{20{slot_inst_q[31]}}, slot_inst_q[31:20]};
  assign imm_s  = {{20{slot_inst_q[31]}}, slot_inst_q[31:25], slot_inst_q[11:7]};
  assign imm_b  = {{19{slot_inst_q[31]}}, slot_inst_q[31], slot_inst_q[7], slot_inst_q[30:25],
                   slot_inst_q[11:8], 1'b0};
  assign imm_u  = {slot_inst_q[31:12], 12'b0};
  assign imm_j  = {{11{slot_inst_q[31]}}, slot_inst_q[31], slot_inst_q[19:12], slot_inst_q[20],
                   slot_inst_q[30:21], 1'b0};
  assign imm_sh = {27'b0, slot_inst_q[24:20]};

  always_comb begin
    dec_type    = `NOPInstType;
    dec_rs1     = 1'b0;
    dec_rs2     = 1'b0;
    dec_rd      = 1'b0;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (opc)
      7'b0110111: begin dec_type = `LUIInstType;   dec_rd = 1'b1; dec_imm = imm_u; end
      7'b0010111: begin dec_type = `AUIPCInstType; dec_rd = 1'b1; dec_imm = imm_u; end
      7'b1101111: begin dec_type = `JALInstType;   dec_rd = 1'b1; dec_imm = imm_j; end
      7'b1100111: begin
        dec_type = `JALRInstType; dec_rs1 = 1'b1; dec_rd = 1'b1; dec_imm = imm_i;
        dec_illegal = (f3 != 3'd0);
      end
      7'b1100011: begin
        dec_rs1 = 1'b1; dec_rs2 = 1'b1; dec_imm = imm_b;
        case (f3)
          3'd0: dec_type = `BEQInstType;
          3'd1: dec_type = `BNEInstType;
          3'd4: dec_type = `BLTInstType;
          3'd5: dec_type = `BGEInstType;
          3'd6: dec_type = `BLTUInstType;
          3'd7: dec_type = `BGEUInstType;
          default: dec_illegal = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec_rs1 = 1'b1; dec_rd = 1'b1; dec_imm = imm_i;
        case (f3)
          3'd0: dec_type = `LBInstType;
          3'd1: dec_type = `LHInstType;
          3'd2: dec_type = `LWInstType;
          3'd4: dec_type = `LBUInstType;
          3'd5: dec_type = `LHUInstType;
          default: dec_illegal = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec_rs1 = 1'b1; dec_rs2 = 1'b1; dec_imm = imm_s;
        case (f3)
          3'd0: dec_type = `SBInstType;
          3'd1: dec_type = `SHInstType;
          3'd2: dec_type = `SWInstType;
          default: dec_illegal = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec_rs1 = 1'b1; dec_rd = 1'b1; dec_imm = imm_i;
        case (f3)
          3'd0: dec_type = `ADDIInstType;
          3'd2: dec_type = `SLTIInstType;
          3'd3: dec_type = `SLTIUInstType;
          3'd4: dec_type = `XORIInstType;
          3'd6: dec_type = `ORIInstType;
          3'd7: dec_type = `ANDIInstType;
          3'd1: begin dec_type = `SLLIInstType; dec_imm = imm_sh; dec_illegal = (f7 != 7'b0000000); end
          default: begin
            dec_imm = imm_sh;
            if (f7 == 7'b0000000)      dec_type = `SRLIInstType;
            else if (f7 == 7'b0100000) dec_type = `SRAIInstType;
            else                       dec_illegal = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        dec_rs1 = 1'b1; dec_rs2 = 1'b1; dec_rd = 1'b1;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'd0: dec_type = `ADDInstType;
              3'd1: dec_type = `SLLInstType;
              3'd2: dec_type = `SLTInstType;
              3'd3: dec_type = `SLTUInstType;
              3'd4: dec_type = `XORInstType;
              3'd5: dec_type = `SRLInstType;
              3'd6: dec_type = `ORInstType;
              default: dec_type = `ANDInstType;
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'd0)      dec_type = `SUBInstType;
            else if (f3 == 3'd5) dec_type = `SRAInstType;
            else                 dec_illegal = 1'b1;
          end
`ifdef RV32M_EN
          7'b0000001: begin
            case (f3)
              3'd0: dec_type = `MULInstType;
              3'd1: dec_type = `MULHInstType;
              3'd2: dec_type = `MULHSUInstType;
              3'd3: dec_type = `MULHUInstType;
              3'd4: dec_type = `DIVInstType;
              3'd5: dec_type = `DIVUInstType;
              3'd6: dec_type = `REMInstType;
              default: dec_type = `REMUInstType;
            endcase
          end
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
    // Illegal encodings still issue, but as an inert NOP that reads and writes nothing.
    if (dec_illegal) begin
      dec_type = `NOPInstType;
      dec_rs1  = 1'b0;
      dec_rs2  = 1'b0;
      dec_rd   = 1'b0;
      dec_imm  = '0;
    end
  end

  assign rs1_read_out = slot_valid_q & dec_rs1;
  assign rs2_read_out = slot_valid_q & dec_rs2;
  assign rs1_addr_out = rs1_read_out ? slot_inst_q[19:15] : 5'd0;
  assign rs2_addr_out = rs2_read_out ? slot_inst_q[24:20] : 5'd0;

  // Returns {hazard, value}. Scanning oldest to youngest lets the youngest match win,
  // so a loading young source also hides any older source for the same register.
  function automatic logic [XLEN:0] resolve(
    input logic [4:0]              addr,
    input logic                    en,
    input logic [XLEN-1:0]         rf,
    input logic [NUM_FWD-1:0]      wreg,
    input logic [NUM_FWD-1:0]      ld,
    input logic [NUM_FWD*5-1:0]    wa,
    input logic [NUM_FWD*XLEN-1:0] wd
  );
    logic [XLEN:0] r;
    r = '0;
    if (en && addr != 5'd0) begin
      r = {1'b0, rf};
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (wreg[i] && wa[5*i +: 5] == addr) r = {ld[i], wd[XLEN*i +: XLEN]};
      end
    end
    return r;
  endfunction

  logic [XLEN:0] rs1_res, rs2_res;
  logic          hazard, advance, accept;

  assign rs1_res = resolve(rs1_addr_out, rs1_read_out, rs1_data_in, fwd_wreg_in, fwd_loading_in,
                           fwd_waddr_in, fwd_wdata_in);
  assign rs2_res = resolve(rs2_addr_out, rs2_read_out, rs2_data_in, fwd_wreg_in, fwd_loading_in,
                           fwd_waddr_in, fwd_wdata_in);

  assign hazard       = slot_valid_q & (rs1_res[XLEN] | rs2_res[XLEN]);
  assign advance      = slot_valid_q & ~hazard & (~ex_valid_q | ex_ready_in);
  assign id_ready_out = ~slot_valid_q | advance;
  assign accept       = if_valid_in & id_ready_out;

  always_comb begin
    issue.inst_type = dec_type;
    issue.rs1_val   = rs1_res[XLEN-1:0];
    issue.rs2_val   = rs2_res[XLEN-1:0];
    issue.imm       = XLEN'($signed(dec_imm));
    issue.rd        = dec_rd;
    issue.rd_addr   = dec_rd ? slot_inst_q[11:7] : 5'd0;
    issue.pc        = slot_pc_q;
    issue.pre       = slot_pre_q;
    issue.illegal   = dec_illegal;
  end

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_inst_d  = slot_inst_q;
    slot_pc_d    = slot_pc_q;
    slot_pre_d   = slot_pre_q;
    ex_valid_d   = ex_valid_q;
    ex_d         = ex_q;
    stall_cnt_d  = stall_cnt_q;
    if (flush_in) begin
      slot_valid_d = 1'b0;
      ex_valid_d   = 1'b0;
    end else begin
      if (accept) begin
        slot_valid_d = 1'b1;
        slot_inst_d  = if_inst_in;
        slot_pc_d    = if_pc_in;
        slot_pre_d   = if_pre_to_take_in;
      end else if (advance) begin
        slot_valid_d = 1'b0;
      end
      if (advance) begin
        ex_valid_d = 1'b1;
        ex_d       = issue;
      end else if (ex_ready_in) begin
        ex_valid_d = 1'b0;
      end
      if (hazard && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot_valid_q <= 1'b0;
      slot_inst_q  <= '0;
      slot_pc_q    <= '0;
      slot_pre_q   <= 1'b0;
      ex_valid_q   <= 1'b0;
      ex_q         <= '{inst_type: `NOPInstType, default: '0};
      stall_cnt_q  <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_inst_q  <= slot_inst_d;
      slot_pc_q    <= slot_pc_d;
      slot_pre_q   <= slot_pre_d;
      ex_valid_q   <= ex_valid_d;
      ex_q         <= ex_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign ex_valid_out       = ex_valid_q;
  assign ex_inst_type_out   = ex_q.inst_type;
  assign ex_rs1_val_out     = ex_q.rs1_val;
  assign ex_rs2_val_out     = ex_q.rs2_val;
  assign ex_imm_out         = ex_q.imm;
  assign ex_rd_out          = ex_q.rd;
  assign ex_rd_addr_out     = ex_q.rd_addr;
  assign ex_pc_out          = ex_q.pc;
  assign ex_pre_to_take_out = ex_q.pre;
  assign ex_illegal_out     = ex_q.illegal;
  assign stall_cnt_out      = stall_cnt_q;

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed bench for id_fwd_stage: an expected-issue queue checked on every EX handshake plus literal checks.
`ifndef InstTypeBus
`define InstTypeBus [5:0]
`endif
`ifndef NOPInstType
`define NOPInstType 6'd0
`endif
`ifndef LUIInstType
`define LUIInstType 6'd1
`endif
`ifndef JALInstType
`define JALInstType 6'd3
`endif
`ifndef BEQInstType
`define BEQInstType 6'd5
`endif
`ifndef SWInstType
`define SWInstType 6'd18
`endif
`ifndef ADDIInstType
`define ADDIInstType 6'd19
`endif
`ifndef SRAIInstType
`define SRAIInstType 6'd27
`endif
`ifndef ADDInstType
`define ADDInstType 6'd28
`endif
`ifndef SUBInstType
`define SUBInstType 6'd29
`endif
`ifndef MULInstType
`define MULInstType 6'd38
`endif

module tb_id_fwd_stage;
  localparam int NUM_FWD = 2;
  localparam int XLEN    = 32;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_in, flush_in, if_valid_in, if_pre_to_take_in, id_ready_out;
  logic [31:0] if_inst_in, if_pc_in;
  logic rs1_read_out, rs2_read_out;
  logic [4:0] rs1_addr_out, rs2_addr_out;
  logic [XLEN-1:0] rs1_data_in, rs2_data_in;
  logic [NUM_FWD-1:0] fwd_wreg_in, fwd_loading_in;
  logic [NUM_FWD*5-1:0] fwd_waddr_in;
  logic [NUM_FWD*XLEN-1:0] fwd_wdata_in;
  logic ex_ready_in, ex_valid_out, ex_rd_out, ex_pre_to_take_out, ex_illegal_out;
  logic `InstTypeBus ex_inst_type_out;
  logic [XLEN-1:0] ex_rs1_val_out, ex_rs2_val_out, ex_imm_out;
  logic [4:0] ex_rd_addr_out;
  logic [31:0] ex_pc_out;
  logic [CNT_W-1:0] stall_cnt_out;

  id_fwd_stage #(.NUM_FWD(NUM_FWD), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_in(clk), .rst_in(rst_in), .flush_in(flush_in),
    .if_valid_in(if_valid_in), .if_inst_in(if_inst_in), .if_pc_in(if_pc_in),
    .if_pre_to_take_in(if_pre_to_take_in), .id_ready_out(id_ready_out),
    .rs1_read_out(rs1_read_out), .rs2_read_out(rs2_read_out),
    .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .fwd_wreg_in(fwd_wreg_in), .fwd_loading_in(fwd_loading_in),
    .fwd_waddr_in(fwd_waddr_in), .fwd_wdata_in(fwd_wdata_in),
    .ex_ready_in(ex_ready_in), .ex_valid_out(ex_valid_out),
    .ex_inst_type_out(ex_inst_type_out), .ex_rs1_val_out(ex_rs1_val_out),
    .ex_rs2_val_out(ex_rs2_val_out), .ex_imm_out(ex_imm_out), .ex_rd_out(ex_rd_out),
    .ex_rd_addr_out(ex_rd_addr_out), .ex_pc_out(ex_pc_out),
    .ex_pre_to_take_out(ex_pre_to_take_out), .ex_illegal_out(ex_illegal_out),
    .stall_cnt_out(stall_cnt_out)
  );

  // Register file model: x0 holds junk so the DUT must force it to zero itself.
  logic [31:0] regs [32];
  assign rs1_data_in = regs[rs1_addr_out];
  assign rs2_data_in = regs[rs2_addr_out];

  typedef struct packed {
    logic [5:0]  ty;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic        rd;
    logic [4:0]  rda;
    logic [31:0] pc;
    logic        pre;
    logic        ill;
  } exp_t;

  exp_t expq[$];
  int tests = 0;
  int fails = 0;

  function automatic exp_t mk(input logic [5:0] ty, input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] imm, input logic rd, input logic [4:0] rda,
                              input logic [31:0] pc, input logic pre, input logic ill);
    exp_t e;
    e.ty = ty; e.r1 = r1; e.r2 = r2; e.imm = imm; e.rd = rd;
    e.rda = rda; e.pc = pc; e.pre = pre; e.ill = ill;
    return e;
  endfunction

  // Every EX handshake must match the oldest outstanding expected issue.
  always @(negedge clk) begin : compare
    exp_t a, e;
    if (!rst_in && ex_valid_out && ex_ready_in) begin
      a = mk(ex_inst_type_out, ex_rs1_val_out, ex_rs2_val_out, ex_imm_out, ex_rd_out,
             ex_rd_addr_out, ex_pc_out, ex_pre_to_take_out, ex_illegal_out);
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL issue_unexpected actual pc=%h ty=%0d required no issue", a.pc, a.ty);
      end else begin
        e = expq.pop_front();
        if (a !== e) begin
          fails++;
          $display("FAIL issue_pc%h actual ty=%0d r1=%h r2=%h imm=%h rd=%0d rda=%0d pc=%h pre=%0d ill=%0d required ty=%0d r1=%h r2=%h imm=%h rd=%0d rda=%0d pc=%h pre=%0d ill=%0d",
                   e.pc, a.ty, a.r1, a.r2, a.imm, a.rd, a.rda, a.pc, a.pre, a.ill,
                   e.ty, e.r1, e.r2, e.imm, e.rd, e.rda, e.pc, e.pre, e.ill);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the offer until ID accepts it; returns 1 time unit after the accepting edge.
  task automatic offer(input logic [31:0] inst, input logic [31:0] pc, input logic pre,
                       input bit push, input exp_t e);
    bit done;
    done = 1'b0;
    if_valid_in = 1'b1; if_inst_in = inst; if_pc_in = pc; if_pre_to_take_in = pre;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (id_ready_out) begin
        done = 1'b1;
        if (push) expq.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    if_valid_in = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL offer_timeout actual=not accepted required=accepted pc=%h", pc);
    end
  endtask

  task automatic set_fwd(input logic [1:0] wreg, input logic [1:0] ld, input logic [4:0] a0,
                         input logic [4:0] a1, input logic [31:0] d0, input logic [31:0] d1);
    fwd_wreg_in = wreg; fwd_loading_in = ld;
    fwd_waddr_in = {a1, a0}; fwd_wdata_in = {d1, d0};
  endtask

  exp_t none;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    none = '0;
    for (int r = 0; r < 32; r++) regs[r] = 32'h1000 + r;
    regs[0] = 32'hDEAD_BEEF;
    rst_in = 1'b1; flush_in = 1'b0; if_valid_in = 1'b0; if_inst_in = '0; if_pc_in = '0;
    if_pre_to_take_in = 1'b0; ex_ready_in = 1'b1;
    set_fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    idle(2);
    rst_in = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ex_valid", 32'(ex_valid_out), 32'd0);
    chk("rst_id_ready", 32'(id_ready_out), 32'd1);
    chk("rst_stall_cnt", 32'(stall_cnt_out), 32'd0);
    chk("rst_inst_type", 32'(ex_inst_type_out), 32'(`NOPInstType));
    chk("rst_pc", ex_pc_out, 32'h0);
    idle(1);

    // addi x1,x0,5: x0 reads as zero, issue one edge after accept
    offer(32'h00500093, 32'h100, 1'b0, 1'b1, mk(`ADDIInstType, 0, 0, 5, 1, 1, 32'h100, 0, 0));
    @(negedge clk);
    chk("addi_not_yet_valid", 32'(ex_valid_out), 32'd0);
    chk("addi_rs1_read", 32'(rs1_read_out), 32'd1);
    chk("addi_rs2_read", 32'(rs2_read_out), 32'd0);
    idle(1);
    @(negedge clk);
    chk("addi_valid", 32'(ex_valid_out), 32'd1);
    chk("addi_imm", ex_imm_out, 32'd5);
    idle(2);

    // Forwarding priority: both sources write x2, youngest wins
    set_fwd(2'b11, 2'b00, 5'd2, 5'd2, 32'hAA, 32'hBB);
    offer(32'h002101B3, 32'h104, 1'b0, 1'b1, mk(`ADDInstType, 32'hAA, 32'hAA, 0, 1, 3, 32'h104, 0, 0));
    idle(3);
    // Only the older source matches rs1, the younger one matches rs2
    set_fwd(2'b11, 2'b00, 5'd4, 5'd2, 32'h44, 32'hBB);
    offer(32'h004101B3, 32'h108, 1'b0, 1'b1, mk(`ADDInstType, 32'hBB, 32'h44, 0, 1, 3, 32'h108, 0, 0));
    idle(3);
    // Source 1 not writing: rs2 comes from the register file
    set_fwd(2'b01, 2'b00, 5'd2, 5'd5, 32'hAA, 32'h55);
    offer(32'h005101B3, 32'h10C, 1'b0, 1'b1, mk(`ADDInstType, 32'hAA, 32'h1005, 0, 1, 3, 32'h10C, 0, 0));
    idle(3);
    chk("pre_stall_cnt", 32'(stall_cnt_out), 32'd0);

    // Load-use: source 0 loading x5 masks ready source 1 for three cycles
    set_fwd(2'b11, 2'b01, 5'd5, 5'd5, 32'h0, 32'h5555);
    offer(32'h40028333, 32'h110, 1'b0, 1'b1, mk(`SUBInstType, 32'h1234, 0, 0, 1, 6, 32'h110, 0, 0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("lu_id_ready", 32'(id_ready_out), 32'd0);
      chk("lu_ex_valid", 32'(ex_valid_out), 32'd0);
      idle(1);
    end
    set_fwd(2'b11, 2'b00, 5'd5, 5'd5, 32'h1234, 32'h5555);
    @(negedge clk);
    chk("lu_stall_cnt", 32'(stall_cnt_out), 32'd3);
    chk("lu_release_ready", 32'(id_ready_out), 32'd1);
    idle(3);
    set_fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

    // EX backpressure: bundle held stable, slot fills, then in-order drain
    ex_ready_in = 1'b0;
    offer(32'h123453B7, 32'h200, 1'b0, 1'b1, mk(`LUIInstType, 0, 0, 32'h12345000, 1, 7, 32'h200, 0, 0));
    offer(32'h008000EF, 32'h204, 1'b1, 1'b1, mk(`JALInstType, 0, 0, 8, 1, 1, 32'h204, 1, 0));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_ex_valid", 32'(ex_valid_out), 32'd1);
      chk("bp_pc", ex_pc_out, 32'h200);
      chk("bp_imm", ex_imm_out, 32'h12345000);
      chk("bp_id_ready", 32'(id_ready_out), 32'd0);
      idle(1);
    end
    ex_ready_in = 1'b1;
    offer(32'hFE208EE3, 32'h208, 1'b1, 1'b1, mk(`BEQInstType, 32'h1001, 32'h1002, 32'hFFFFFFFC, 0, 0, 32'h208, 1, 0));
    offer(32'hFE20AC23, 32'h20C, 1'b0, 1'b1, mk(`SWInstType, 32'h1001, 32'h1002, 32'hFFFFFFF8, 0, 0, 32'h20C, 0, 0));
    offer(32'h41F0D293, 32'h210, 1'b0, 1'b1, mk(`SRAIInstType, 32'h1001, 0, 32'd31, 1, 5, 32'h210, 0, 0));
    offer(32'hFFFFFFFF, 32'h214, 1'b0, 1'b1, mk(`NOPInstType, 0, 0, 0, 0, 0, 32'h214, 0, 1));
    idle(4);
    chk("drain_queue_empty", 32'(expq.size()), 32'd0);

    // Flush with slot and output full, concurrent offer discarded
    ex_ready_in = 1'b0;
    offer(32'h00100113, 32'h300, 1'b0, 1'b0, none);
    offer(32'h00200193, 32'h304, 1'b0, 1'b0, none);
    if_valid_in = 1'b1; if_inst_in = 32'h00300213; if_pc_in = 32'h308; flush_in = 1'b1;
    idle(1);
    flush_in = 1'b0; if_valid_in = 1'b0;
    @(negedge clk);
    chk("flush_ex_valid", 32'(ex_valid_out), 32'd0);
    chk("flush_id_ready", 32'(id_ready_out), 32'd1);
    chk("flush_stall_cnt", 32'(stall_cnt_out), 32'd3);
    // Flush beats an accept into an empty slot
    idle(1);
    if_valid_in = 1'b1; if_inst_in = 32'h00400293; if_pc_in = 32'h30C; flush_in = 1'b1;
    idle(1);
    flush_in = 1'b0; if_valid_in = 1'b0;
    ex_ready_in = 1'b1;
    idle(3);
    @(negedge clk);
    chk("flush_nothing_issued", 32'(ex_valid_out), 32'd0);
    idle(1);

    // mul x0,x1,x2
`ifdef RV32M_EN
    offer(32'h02208033, 32'h400, 1'b0, 1'b1, mk(`MULInstType, 32'h1001, 32'h1002, 0, 1, 0, 32'h400, 0, 0));
`else
    offer(32'h02208033, 32'h400, 1'b0, 1'b1, mk(`NOPInstType, 0, 0, 0, 0, 0, 32'h400, 0, 1));
`endif
    idle(3);
    chk("mul_queue_empty", 32'(expq.size()), 32'd0);

    // Reset mid-backpressure clears everything including the stall counter
    ex_ready_in = 1'b0;
    offer(32'h00500093, 32'h500, 1'b0, 1'b0, none);
    offer(32'h00600093, 32'h504, 1'b0, 1'b0, none);
    rst_in = 1'b1;
    idle(1);
    rst_in = 1'b0;
    ex_ready_in = 1'b1;
    @(negedge clk);
    chk("rst2_ex_valid", 32'(ex_valid_out), 32'd0);
    chk("rst2_id_ready", 32'(id_ready_out), 32'd1);
    chk("rst2_stall_cnt", 32'(stall_cnt_out), 32'd0);
    chk("rst2_pc", ex_pc_out, 32'h0);
    idle(3);
    chk("final_queue_empty", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
